prog_clock_divider: RTL and testbench
=====================================

Name: prog_clock_divider

Overview:
- Runtime-programmable clock divider that generates the divided clock and a companion single-cycle tick strobe for downstream logic in the clk_in domain.
- Divide ratio is updated through a load/ack handshake. A new ratio is applied only at a period boundary, so clk_out never glitches or produces a runt phase.
- Sits directly alongside the fixed clock_divider and supersedes it where the ratio must change at run time.

Parameters:
- DIV_W, 16, width of divide-ratio input and internal counter.
- DEFAULT_DIV, 2, ratio in force after reset; must be 2..2**DIV_W-1.

Ports:
- clk_in, input, 1, source clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, run (1) / stop (0).
- div_val, input, DIV_W, requested divide ratio N; sampled with div_load.
- div_load, input, 1, request to load div_val.
- div_ack, output, 1, one-cycle pulse when the pending ratio is committed.
- busy, output, 1, a load is pending and not yet committed.
- clk_out, output, 1, divided clock, registered.
- tick, output, 1, one-cycle strobe in the last cycle of each clk_out period.

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, ratio=DEFAULT_DIV, pending=0, state=STOPPED.
  - clk_out=0, tick=0, div_ack=0, busy=0.
- Ratio clamp: effective N = max(div_val, 2). Values 0 and 1 commit as 2.
- Period: cycle index c counts 0..N-1 and wraps to 0. H = floor(N/2).
  - clk_out=1 for c<H, otherwise 0.
  - Odd N: the low phase is one cycle longer.
  - tick=1 exactly when c=N-1.
- All outputs are registered. clk_out and tick change only on clk_in rising edges.
- States:
  - STOPPED: cnt held at 0; clk_out=0, tick=0.
    - enable=1 -> RUN. clk_out goes 1 on the first rising edge after enable is sampled high (c=0).
  - RUN: counting.
    - enable sampled 0 -> STOPPED at the next edge. The current period is abandoned, cnt=0, clk_out=0.
    - Load accepted -> PENDING.
  - PENDING: counting with the old ratio, busy=1.
    - At the wrap edge (c=N-1 -> 0), ratio<=pending, div_ack=1 for one cycle, busy=0, state -> RUN. The new period starts with the new ratio.
    - enable=0 in PENDING: commit immediately at that edge, div_ack=1, state -> STOPPED.
- Load acceptance: div_load sampled 1 while busy=0 captures div_val.
  - In STOPPED, commit takes effect at that same edge: div_ack=1 next cycle, busy never asserts.
  - div_load while busy=1 is ignored; no ack is produced.
- Simultaneous events:
  - enable rising with div_load in STOPPED: the new ratio is used for the very first period.
  - div_load on the wrap cycle in RUN: captured into PENDING; commits at the following wrap, not the current one.
- Loading the same value as the current ratio still follows the full handshake.
- Reset mid-period aborts the period immediately (async). Any pending load is discarded and the ratio returns to DEFAULT_DIV.

Decomposition:
- Package clock_divider_pkg holds:
  - the state enum typedef (STOPPED, RUN, PENDING);
  - the localparam MIN_DIV=2;
  - a function computing H from N.
- No sub-module is needed: counter, FSM and handshake fit in one module of about 150–250 lines.

Test Plan:
- Reset, enable=1, DEFAULT_DIV=2 -> clk_out toggles every cycle (1,0,1,0); tick=1 on every second cycle, coincident with clk_out=0.
- In STOPPED, load div_val=5 then enable -> clk_out 1,1,0,0,0 repeating; tick on the 5th cycle of each period; div_ack pulses once before the first period and busy stays 0.
- Running N=4, load div_val=6 at c=1 -> busy=1 until the wrap. Remaining cycles follow the 1,1,0,0 pattern, then div_ack pulses and the next periods are 1,1,1,0,0,0. No period other than 4 or 6 cycles is observed.
- While busy, issue a second div_load=3 -> ignored. Only one div_ack; the ratio becomes the first requested value.
- div_val=0 load -> behaves as N=2. enable dropped mid-period (N=8, c=3) -> clk_out=0 and tick=0 at the next edge. Re-enable restarts at c=0 with clk_out=1.
- Assert rst_n low asynchronously mid-period while PENDING -> all outputs 0 immediately. After release and enable, the period equals DEFAULT_DIV.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clock_divider_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } div_state_e;

  localparam int MIN_DIV = 2;

  // High-phase length: odd ratios put the extra cycle in the low phase.
  function automatic logic [31:0] half_period(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider with glitch-free ratio updates
// through a load/ack handshake; also emits a last-cycle tick strobe.
module prog_clock_divider
  import clock_divider_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             busy,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] MIN_N = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  div_state_e       r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0] r_ratio, w_ratio_nxt;
  logic [DIV_W-1:0] r_pend, w_pend_nxt;
  logic             r_clk, r_tick, r_ack, r_busy;
  logic             w_clk_nxt, w_tick_nxt, w_ack_nxt, w_busy_nxt;
  logic             w_run, w_last, w_accept;
  logic [DIV_W-1:0] w_cnt_inc, w_load_n;

  assign w_last    = (r_cnt == r_ratio - ONE);
  assign w_cnt_inc = w_last ? '0 : r_cnt + ONE;
  assign w_load_n  = (div_val < MIN_N) ? MIN_N : div_val;
  assign w_accept  = div_load && !r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ratio_nxt = r_ratio;
    w_pend_nxt  = r_pend;
    w_ack_nxt   = 1'b0;
    w_busy_nxt  = r_busy;
    w_run       = 1'b0;
    w_clk_nxt   = 1'b0;
    w_tick_nxt  = 1'b0;

    case (r_state)
      STOPPED: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_ratio_nxt = w_load_n;
          w_ack_nxt   = 1'b1;
        end
        if (enable) begin
          w_state_nxt = RUN;
          w_run       = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          // A load racing the stop commits straight away, as in STOPPED.
          w_state_nxt = STOPPED;
          w_cnt_nxt   = '0;
          if (w_accept) begin
            w_ratio_nxt = w_load_n;
            w_ack_nxt   = 1'b1;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          w_run     = 1'b1;
          if (w_accept) begin
            w_pend_nxt  = w_load_n;
            w_busy_nxt  = 1'b1;
            w_state_nxt = PENDING;
          end
        end
      end
      PENDING: begin
        if (!enable) begin
          w_ratio_nxt = r_pend;
          w_ack_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = STOPPED;
        end else if (w_last) begin
          w_ratio_nxt = r_pend;
          w_ack_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
          w_run       = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          w_run     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = STOPPED;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Outputs are derived from the next index/ratio so they register in step.
    if (w_run) begin
      w_clk_nxt  = 32'(w_cnt_nxt) < half_period(32'(w_ratio_nxt));
      w_tick_nxt = (w_cnt_nxt == w_ratio_nxt - ONE);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STOPPED;
      r_cnt   <= '0;
      r_ratio <= DEF_N;
      r_pend  <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ratio <= w_ratio_nxt;
      r_pend  <= w_pend_nxt;
      r_clk   <= w_clk_nxt;
      r_tick  <= w_tick_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign clk_out = r_clk;
  assign tick    = r_tick;
  assign div_ack = r_ack;
  assign busy    = r_busy;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider; inputs change and outputs are
// checked on the falling edge of clk_in.
module tb_prog_clock_divider;

  localparam int DIV_W = 16;

  logic             clk_in;
  logic             rst_n;
  logic             enable;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             busy;
  logic             clk_out;
  logic             tick;

  int tests;
  int fails;

  prog_clock_divider #(.DIV_W(DIV_W), .DEFAULT_DIV(2)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .enable  (enable),
    .div_val (div_val),
    .div_load(div_load),
    .div_ack (div_ack),
    .busy    (busy),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; div_load = 1'b0; div_val = '0;
    repeat (3) @(negedge clk_in);
    tests++; if (clk_out !== 1'b0) begin fails++; $display("FAIL reset_clk got %b exp 0", clk_out); end
    tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b exp 0", tick); end
    tests++; if (div_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b exp 0", div_ack); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_default();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      tests++; if (clk_out !== ((i % 2) == 0)) begin fails++; $display("FAIL def_clk i=%0d got %b", i, clk_out); end
      tests++; if (tick !== ((i % 2) == 1)) begin fails++; $display("FAIL def_tick i=%0d got %b", i, tick); end
    end
    enable = 1'b0;
    @(negedge clk_in);
    tests++; if (clk_out !== 1'b0 || tick !== 1'b0) begin fails++; $display("FAIL def_stop clk=%b tick=%b exp 0 0", clk_out, tick); end
  endtask

  task automatic test_load_stopped();
    div_val = 16'd5; div_load = 1'b1;
    @(negedge clk_in);
    tests++; if (div_ack !== 1'b1) begin fails++; $display("FAIL ld5_ack got %b exp 1", div_ack); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ld5_busy got %b exp 0", busy); end
    div_load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      tests++; if (clk_out !== ((i % 5) < 2)) begin fails++; $display("FAIL n5_clk i=%0d got %b", i, clk_out); end
      tests++; if (tick !== ((i % 5) == 4)) begin fails++; $display("FAIL n5_tick i=%0d got %b", i, tick); end
      tests++; if (div_ack !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL n5_hs i=%0d ack=%b busy=%b exp 0 0", i, div_ack, busy); end
    end
    enable = 1'b0;
    @(negedge clk_in);
  endtask

  // N=4 running, load 6 at c=1, a second load of 3 while busy must be dropped.
  task automatic test_pending();
    logic [0:15] e_clk  = 16'b1100_1110_0011_1000;
    logic [0:15] e_tick = 16'b0001_0000_0100_0001;
    logic [0:15] e_ack  = 16'b0000_1000_0000_0000;
    logic [0:15] e_busy = 16'b0011_0000_0000_0000;
    int acks = 0;
    div_val = 16'd4; div_load = 1'b1;
    @(negedge clk_in);
    div_load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      if (div_ack === 1'b1) acks++;
      tests++; if (clk_out !== e_clk[i]) begin fails++; $display("FAIL pend_clk i=%0d got %b exp %b", i, clk_out, e_clk[i]); end
      tests++; if (tick !== e_tick[i]) begin fails++; $display("FAIL pend_tick i=%0d got %b exp %b", i, tick, e_tick[i]); end
      tests++; if (div_ack !== e_ack[i]) begin fails++; $display("FAIL pend_ack i=%0d got %b exp %b", i, div_ack, e_ack[i]); end
      tests++; if (busy !== e_busy[i]) begin fails++; $display("FAIL pend_busy i=%0d got %b exp %b", i, busy, e_busy[i]); end
      if (i == 1) begin div_val = 16'd6; div_load = 1'b1; end
      if (i == 2) begin div_val = 16'd3; div_load = 1'b1; end
      if (i == 3) div_load = 1'b0;
    end
    tests++; if (acks != 1) begin fails++; $display("FAIL pend_ack_count got %0d exp 1", acks); end
    enable = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_zero_and_stop();
    div_val = 16'd0; div_load = 1'b1;
    @(negedge clk_in);
    tests++; if (div_ack !== 1'b1) begin fails++; $display("FAIL ld0_ack got %b exp 1", div_ack); end
    div_load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      tests++; if (clk_out !== ((i % 2) == 0)) begin fails++; $display("FAIL n0_clk i=%0d got %b", i, clk_out); end
      tests++; if (tick !== ((i % 2) == 1)) begin fails++; $display("FAIL n0_tick i=%0d got %b", i, tick); end
    end
    enable = 1'b0;
    @(negedge clk_in);
    div_val = 16'd8; div_load = 1'b1;
    @(negedge clk_in);
    div_load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      tests++; if (clk_out !== 1'b1) begin fails++; $display("FAIL n8_hi i=%0d got %b exp 1", i, clk_out); end
    end
    enable = 1'b0;
    @(negedge clk_in);
    tests++; if (clk_out !== 1'b0 || tick !== 1'b0) begin fails++; $display("FAIL n8_abort clk=%b tick=%b exp 0 0", clk_out, tick); end
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      tests++; if (clk_out !== (i < 4)) begin fails++; $display("FAIL n8_clk i=%0d got %b", i, clk_out); end
      tests++; if (tick !== (i == 7)) begin fails++; $display("FAIL n8_tick i=%0d got %b", i, tick); end
    end
    enable = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_reset_pending();
    div_val = 16'd6; div_load = 1'b1;
    @(negedge clk_in);
    div_load = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk_in);
    div_val = 16'd10; div_load = 1'b1;
    @(negedge clk_in);
    div_load = 1'b0;
    tests++; if (busy !== 1'b1 || clk_out !== 1'b1) begin fails++; $display("FAIL rp_pre busy=%b clk=%b exp 1 1", busy, clk_out); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (clk_out !== 1'b0) begin fails++; $display("FAIL rp_clk got %b exp 0", clk_out); end
    tests++; if (busy !== 1'b0 || tick !== 1'b0 || div_ack !== 1'b0) begin fails++; $display("FAIL rp_outs busy=%b tick=%b ack=%b exp 0 0 0", busy, tick, div_ack); end
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      tests++; if (clk_out !== ((i % 2) == 0)) begin fails++; $display("FAIL rp_clk2 i=%0d got %b", i, clk_out); end
      tests++; if (tick !== ((i % 2) == 1)) begin fails++; $display("FAIL rp_tick2 i=%0d got %b", i, tick); end
      tests++; if (div_ack !== 1'b0) begin fails++; $display("FAIL rp_ack2 i=%0d got %b exp 0", i, div_ack); end
    end
    enable = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_default();
    test_load_stopped();
    test_pending();
    test_zero_and_stop();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
